mac_io_shell: RTL and testbench
===============================

Name: mac_io_shell

Overview:
- Parametrised pad-side I/O shell for the MAC cores; successor to the fixed 128-bit register-all wrapper.
- Registers reset and load_iv into the core, serves the core's key/message block requests from a narrow external bus (BUS_W), and serialises the core's BLOCK_W result back out.
- Adds ready/valid beat handshakes on both sides, independent input and output paths, and sticky protocol-error reporting.

Parameters:
- BLOCK_W, 128: core block width in bits.
- BUS_W, 32: external data bus width in bits; BLOCK_W % BUS_W == 0 and BUS_W <= BLOCK_W (elaboration error otherwise); BEATS = BLOCK_W/BUS_W.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- load_iv  in  1  external start/IV-load strobe
- ext_req_k  out  1  shell is collecting a key block
- ext_req_m  out  1  shell is collecting a message block
- ext_valid  in  1  ext_din beat valid
- ext_din  in  BUS_W  input beat
- ext_ready  out  1  shell accepts a beat this cycle
- ext_dout_valid  out  1  ext_dout beat valid
- ext_dout  out  BUS_W  output beat
- ext_dout_ready  in  1  host accepts the output beat
- done  out  1  one-cycle pulse after the last result beat is accepted
- err  out  1  sticky protocol error; cleared only by rst
- core_rst  out  1  rst delayed one cycle
- core_load_iv  out  1  load_iv delayed one cycle
- core_load_k  in  1  core key-block request pulse
- core_load_m  in  1  core message-block request pulse
- core_din  out  BLOCK_W  assembled block to core
- core_din_valid  out  1  one-cycle pulse; core_din valid
- core_dout  in  BLOCK_W  core result
- core_done  in  1  core result-valid pulse

Behaviour:
- Reset values: all outputs 0 except core_rst, which follows rst one cycle late. Both FSMs go to IDLE; beat counters and err clear.
- Reset mid-operation: aborts any fill or drain. Partial data is discarded and no done or core_din_valid pulse is produced.
- core_rst and core_load_iv are plain one-cycle delay registers with no gating.
- Input FSM:
  - IDLE -> FILL on core_load_k or core_load_m. The kind is latched; ext_req_k or ext_req_m rises the next cycle and stays high through FILL.
  - If core_load_k and core_load_m arrive together: take the key, set err.
  - FILL: ext_ready = 1. Each ext_valid & ext_ready shifts ext_din into the block register, first beat = most significant word.
  - On the BEATS-th accepted beat -> DELIVER. ext_ready and ext_req_* drop the next cycle.
  - DELIVER (one cycle): core_din_valid = 1, core_din = assembled block; -> IDLE.
  - core_din holds its value until the next DELIVER.
  - Latency from request to core_din_valid = BEATS + 2 cycles with ext_valid held high.
  - core_load_k/m in FILL or DELIVER: ignored, err set.
- Output FSM, independent of the input FSM:
  - IDLE: core_done captures core_dout into the output buffer -> DRAIN.
  - DRAIN: ext_dout_valid = 1, ext_dout = current word, most significant first.
  - Word advances only on ext_dout_valid & ext_dout_ready. ext_dout is stable while ready is low.
  - After the BEATS-th accepted beat: ext_dout_valid drops, done pulses for one cycle the next cycle, -> IDLE.
  - core_done in DRAIN: result dropped, buffer unchanged, err set.
  - core_done in the same cycle as the final accept: also an overrun; the buffer is not reloaded.
- Simultaneous input request and core_done are both handled, since the paths are independent.
- Beat counters are log2(BEATS)+1 bits wide and do not wrap within a block.
- BEATS = 1 is legal: FILL lasts one accepted beat.

Test Plan (BLOCK_W=128, BUS_W=32):
- Key fill: core_load_k pulse, then beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with ext_valid held high -> ext_req_k high for 4 cycles; core_din_valid pulses once with core_din = 0x00112233_44556677_8899AABB_CCDDEEFF, 6 cycles after the request.
- Stalled message fill: core_load_m, with ext_valid toggling 1,0,1,0,... -> ext_req_m held until the 4th accepted beat; block correct; err = 0.
- Result drain with backpressure: core_done with core_dout = 0xA5A5...A5 plus beat index pattern; ext_dout_ready low for 3 cycles mid-drain -> ext_dout stable while stalled, 4 words emitted MSW first, then a single done pulse.
- Overrun cases:
  - second core_done during DRAIN -> the first result drains unchanged and err = 1.
  - core_load_k during FILL -> err = 1 and the block is unaffected.
- Reset mid-fill: rst asserted after 2 beats -> ext_ready, ext_req_k and err are 0 next cycle; core_rst is high one cycle after rst; a subsequent fresh 4-beat fill delivers the correct block.
- Concurrency: core_load_m in the same cycle as core_done -> fill and drain proceed in parallel; both the block and the result are correct and err = 0.

Source files
------------

// File: rtl/mac_io_shell.sv
// mac_io_shell: pad-side I/O shell for the MAC cores. Bridges the core's BLOCK_W
// block interface to a narrow BUS_W ready/valid beat bus in both directions.
module mac_io_shell #(
    parameter int BLOCK_W = 128,
    parameter int BUS_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_iv,
    output logic               ext_req_k,
    output logic               ext_req_m,
    input  logic               ext_valid,
    input  logic [BUS_W-1:0]   ext_din,
    output logic               ext_ready,
    output logic               ext_dout_valid,
    output logic [BUS_W-1:0]   ext_dout,
    input  logic               ext_dout_ready,
    output logic               done,
    output logic               err,
    output logic               core_rst,
    output logic               core_load_iv,
    input  logic               core_load_k,
    input  logic               core_load_m,
    output logic [BLOCK_W-1:0] core_din,
    output logic               core_din_valid,
    input  logic [BLOCK_W-1:0] core_dout,
    input  logic               core_done
);
    localparam int BEATS = BLOCK_W / BUS_W;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((BUS_W > BLOCK_W) || ((BLOCK_W % BUS_W) != 0)) begin : g_param_check
        $error("mac_io_shell: BLOCK_W must be a multiple of BUS_W and BUS_W <= BLOCK_W");
    end

    typedef enum logic [1:0] {
        IN_IDLE    = 2'd0,
        IN_FILL    = 2'd1,
        IN_DELIVER = 2'd2
    } in_state_e;

    typedef enum logic {
        OUT_IDLE  = 1'b0,
        OUT_DRAIN = 1'b1
    } out_state_e;

    in_state_e          in_state_q;
    out_state_e         out_state_q;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic [BLOCK_W-1:0] blk_q;
    logic [BLOCK_W-1:0] blk_d;
    logic [BLOCK_W-1:0] obuf_q;
    logic [BLOCK_W-1:0] obuf_d;
    logic [BLOCK_W-1:0] core_din_q;
    logic               core_din_valid_q;
    logic               ext_req_k_q;
    logic               ext_req_m_q;
    logic               ext_ready_q;
    logic               ext_dout_valid_q;
    logic               done_q;
    logic               err_q;
    logic               err_d;
    logic               core_rst_q;
    logic               core_load_iv_q;
    logic               in_accept_s;
    logic               out_accept_s;

    // Beats arrive most significant word first, so each accept shifts the block left.
    assign blk_d        = (blk_q << BUS_W) | BLOCK_W'(ext_din);
    assign obuf_d       = obuf_q << BUS_W;
    assign in_accept_s  = ext_valid & ext_ready_q;
    assign out_accept_s = ext_dout_valid_q & ext_dout_ready;

    // Protocol violations: dual request, request while busy, result while draining.
    assign err_d = err_q
                 | ((in_state_q == IN_IDLE) ? (core_load_k & core_load_m)
                                            : (core_load_k | core_load_m))
                 | ((out_state_q == OUT_DRAIN) & core_done);

    // Input path: collect a requested block from the beat bus and hand it to the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q       <= IN_IDLE;
            in_cnt_q         <= '0;
            blk_q            <= '0;
            core_din_q       <= '0;
            core_din_valid_q <= 1'b0;
            ext_req_k_q      <= 1'b0;
            ext_req_m_q      <= 1'b0;
            ext_ready_q      <= 1'b0;
        end else begin
            core_din_valid_q <= 1'b0;
            case (in_state_q)
                IN_IDLE: begin
                    if (core_load_k || core_load_m) begin
                        in_state_q  <= IN_FILL;
                        in_cnt_q    <= '0;
                        ext_req_k_q <= core_load_k;
                        ext_req_m_q <= ~core_load_k;
                        ext_ready_q <= 1'b1;
                    end
                end
                IN_FILL: begin
                    if (in_accept_s) begin
                        blk_q <= blk_d;
                        if (in_cnt_q == LAST_BEAT) begin
                            in_state_q  <= IN_DELIVER;
                            in_cnt_q    <= '0;
                            ext_req_k_q <= 1'b0;
                            ext_req_m_q <= 1'b0;
                            ext_ready_q <= 1'b0;
                        end else begin
                            in_cnt_q <= in_cnt_q + CNT_W'(1);
                        end
                    end
                end
                IN_DELIVER: begin
                    core_din_q       <= blk_q;
                    core_din_valid_q <= 1'b1;
                    in_state_q       <= IN_IDLE;
                end
                default: begin
                    in_state_q  <= IN_IDLE;
                    ext_req_k_q <= 1'b0;
                    ext_req_m_q <= 1'b0;
                    ext_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Output path: capture a core result and serialise it onto the beat bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_q      <= OUT_IDLE;
            out_cnt_q        <= '0;
            obuf_q           <= '0;
            ext_dout_valid_q <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (out_state_q)
                OUT_IDLE: begin
                    if (core_done) begin
                        obuf_q           <= core_dout;
                        out_cnt_q        <= '0;
                        ext_dout_valid_q <= 1'b1;
                        out_state_q      <= OUT_DRAIN;
                    end
                end
                OUT_DRAIN: begin
                    if (out_accept_s) begin
                        obuf_q <= obuf_d;
                        if (out_cnt_q == LAST_BEAT) begin
                            out_cnt_q        <= '0;
                            ext_dout_valid_q <= 1'b0;
                            done_q           <= 1'b1;
                            out_state_q      <= OUT_IDLE;
                        end else begin
                            out_cnt_q <= out_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    out_state_q      <= OUT_IDLE;
                    ext_dout_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag plus the one-cycle delayed control strobes to the core.
    always_ff @(posedge clk) begin
        core_rst_q <= rst;
        if (rst) begin
            err_q          <= 1'b0;
            core_load_iv_q <= 1'b0;
        end else begin
            err_q          <= err_d;
            core_load_iv_q <= load_iv;
        end
    end

    assign ext_req_k      = ext_req_k_q;
    assign ext_req_m      = ext_req_m_q;
    assign ext_ready      = ext_ready_q;
    assign ext_dout_valid = ext_dout_valid_q;
    assign ext_dout       = obuf_q[BLOCK_W-1 -: BUS_W];
    assign done           = done_q;
    assign err            = err_q;
    assign core_rst       = core_rst_q;
    assign core_load_iv   = core_load_iv_q;
    assign core_din       = core_din_q;
    assign core_din_valid = core_din_valid_q;

endmodule

// File: tb/tb_mac_io_shell.sv
// Self-checking bench for mac_io_shell (BLOCK_W=128, BUS_W=32): directed steps
// plus randomized blocks scored against a queue-based block/word model.
module tb_mac_io_shell;
    localparam int BLOCK_W = 128;
    localparam int BUS_W   = 32;
    localparam int BEATS   = 4;

    logic               clk = 1'b0;
    logic               rst, load_iv, ext_valid, ext_dout_ready;
    logic               core_load_k, core_load_m, core_done;
    logic [BUS_W-1:0]   ext_din, ext_dout;
    logic [BLOCK_W-1:0] core_din, core_dout;
    logic               ext_req_k, ext_req_m, ext_ready, ext_dout_valid;
    logic               done, err, core_rst, core_load_iv, core_din_valid;

    int n_cmp = 0;
    int n_mis = 0;
    int done_seen = 0;
    int done_exp = 0;
    logic [BLOCK_W-1:0] got_blk[$];
    logic [BLOCK_W-1:0] exp_blk[$];
    logic [BUS_W-1:0]   got_words[$];
    logic [BUS_W-1:0]   exp_words[$];

    always #5 clk = ~clk;

    mac_io_shell #(.BLOCK_W(BLOCK_W), .BUS_W(BUS_W)) dut (
        .clk(clk), .rst(rst), .load_iv(load_iv),
        .ext_req_k(ext_req_k), .ext_req_m(ext_req_m),
        .ext_valid(ext_valid), .ext_din(ext_din), .ext_ready(ext_ready),
        .ext_dout_valid(ext_dout_valid), .ext_dout(ext_dout), .ext_dout_ready(ext_dout_ready),
        .done(done), .err(err), .core_rst(core_rst), .core_load_iv(core_load_iv),
        .core_load_k(core_load_k), .core_load_m(core_load_m),
        .core_din(core_din), .core_din_valid(core_din_valid),
        .core_dout(core_dout), .core_done(core_done)
    );

    // Collect everything the shell hands out, sampled mid-cycle.
    always @(negedge clk) begin
        if (core_din_valid) got_blk.push_back(core_din);
        if (ext_dout_valid && ext_dout_ready) got_words.push_back(ext_dout);
        if (done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        logic [127:0] t;
        t = b >> (BUS_W * (BEATS - 1 - i));
        return t[31:0];
    endfunction

    task automatic push_result(input logic [127:0] res);
        for (int i = 0; i < BEATS; i++) exp_words.push_back(word_of(res, i));
        done_exp++;
    endtask

    // Request a block, then feed its words; optionally stall, inject a key request, or fire core_done.
    task automatic fill_block(input bit is_key, input logic [127:0] blk, input bit stall,
                              input int inj, input bit with_done, input logic [127:0] res);
        int  i;
        int  cyc;
        bit  ph;
        bit  acc;
        core_load_k = is_key;
        core_load_m = !is_key;
        if (with_done) begin
            core_done = 1'b1;
            core_dout = res;
            push_result(res);
        end
        tick();
        core_load_k = 1'b0;
        core_load_m = 1'b0;
        core_done   = 1'b0;
        i = 0; cyc = 0; ph = 1'b1;
        while (i < BEATS && cyc < 64) begin
            check("fill_req", 128'({ext_req_k, ext_req_m, ext_ready}), 128'({is_key, !is_key, 1'b1}));
            ext_valid   = stall ? ph : 1'b1;
            ext_din     = ext_valid ? word_of(blk, i) : 32'($urandom);
            core_load_k = (cyc == inj);
            acc = ext_valid && ext_ready;
            tick();
            core_load_k = 1'b0;
            if (acc) i++;
            ph = !ph;
            cyc++;
        end
        ext_valid = 1'b0;
        check("fill_beats", 128'(i), 128'(BEATS));
        check("fill_end", 128'({ext_req_k, ext_req_m, ext_ready}), 128'(0));
        exp_blk.push_back(blk);
    endtask

    // Let the output path finish all expected drains; stalled words must hold.
    task automatic run_drain(input bit random_ready);
        bit          stalled;
        logic [31:0] held;
        stalled = 1'b0;
        held = '0;
        for (int k = 0; k < 80 && done_seen < done_exp; k++) begin
            if (stalled) check("dout_stable", 128'(ext_dout), 128'(held));
            ext_dout_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = ext_dout_valid && !ext_dout_ready;
            held = ext_dout;
            tick();
        end
        ext_dout_ready = 1'b1;
        check("drain_done", 128'(done_seen), 128'(done_exp));
    endtask

    task automatic scoreboard(input string tag);
        check($sformatf("%s_nblk", tag), 128'(got_blk.size()), 128'(exp_blk.size()));
        while (got_blk.size() > 0 && exp_blk.size() > 0)
            check($sformatf("%s_blk", tag), got_blk.pop_front(), exp_blk.pop_front());
        check($sformatf("%s_nwords", tag), 128'(got_words.size()), 128'(exp_words.size()));
        while (got_words.size() > 0 && exp_words.size() > 0)
            check($sformatf("%s_word", tag), 128'(got_words.pop_front()), 128'(exp_words.pop_front()));
        check($sformatf("%s_ndone", tag), 128'(done_seen), 128'(done_exp));
        got_blk.delete(); exp_blk.delete(); got_words.delete(); exp_words.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [127:0] blk;
        logic [127:0] res;
        logic [127:0] res2;
        bit           wd;

        rst = 1'b1; load_iv = 1'b0; ext_valid = 1'b0; ext_din = '0; ext_dout_ready = 1'b1;
        core_load_k = 1'b0; core_load_m = 1'b0; core_done = 1'b0; core_dout = '0;
        settle(3);
        check("rst_ctrl", 128'({ext_req_k, ext_req_m, ext_ready, ext_dout_valid, done, err,
                                core_load_iv, core_din_valid}), 128'(0));
        check("rst_data", 128'({core_din, ext_dout}), 128'(0));
        check("rst_core_rst", 128'(core_rst), 128'(1));
        rst = 1'b0;
        tick();
        check("core_rst_release", 128'(core_rst), 128'(0));

        load_iv = 1'b1;
        tick();
        load_iv = 1'b0;
        check("load_iv_delay", 128'(core_load_iv), 128'(1));
        tick();
        check("load_iv_pulse", 128'(core_load_iv), 128'(0));

        // Key fill with ext_valid held high: delivery lands six cycles after the request.
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        fill_block(1'b1, blk, 1'b0, -1, 1'b0, 128'h0);
        check("key_lat5", 128'(core_din_valid), 128'(0));
        tick();
        check("key_lat6", {127'h0, core_din_valid}, 128'(1));
        check("key_block", core_din, blk);
        settle(2);
        scoreboard("key");
        check("key_err", 128'(err), 128'(0));

        blk = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        fill_block(1'b0, blk, 1'b1, -1, 1'b0, 128'h0);
        settle(3);
        scoreboard("msg_stall");
        check("msg_stall_err", 128'(err), 128'(0));

        // Result drain with three stall cycles after the first word.
        res = {32'hA5A5A5A5, 32'hA5A5A5A6, 32'hA5A5A5A7, 32'hA5A5A5A8};
        ext_dout_ready = 1'b1;
        core_done = 1'b1; core_dout = res; push_result(res);
        tick();
        core_done = 1'b0;
        check("bp_w0", 128'({ext_dout_valid, ext_dout}), 128'({1'b1, word_of(res, 0)}));
        tick();
        check("bp_w1", 128'(ext_dout), 128'(word_of(res, 1)));
        ext_dout_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("bp_stall", 128'({ext_dout_valid, ext_dout}), 128'({1'b1, word_of(res, 1)}));
        end
        run_drain(1'b0);
        settle(3);
        scoreboard("bp");
        check("bp_err", 128'(err), 128'(0));

        blk = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
        res = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        fill_block(1'b0, blk, 1'b0, -1, 1'b1, res);
        run_drain(1'b0);
        settle(3);
        scoreboard("conc");
        check("conc_err", 128'(err), 128'(0));

        for (int t = 0; t < 6; t++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            res = {$urandom, $urandom, $urandom, $urandom};
            wd  = 1'($urandom_range(0, 1));
            fill_block(1'($urandom_range(0, 1)), blk, 1'($urandom_range(0, 1)), -1, wd, res);
            settle(3);
            if (!wd) begin
                core_done = 1'b1; core_dout = res; push_result(res);
                tick();
                core_done = 1'b0;
            end
            run_drain(1'b1);
            settle(3);
            scoreboard("rnd");
        end
        check("rnd_err", 128'(err), 128'(0));

        // Key request injected mid message fill: ignored, flagged.
        blk = 128'h11111111_22222222_33333333_44444444;
        fill_block(1'b0, blk, 1'b0, 1, 1'b0, 128'h0);
        settle(3);
        scoreboard("inj");
        check("inj_err", 128'(err), 128'(1));
        do_reset();
        check("inj_err_clr", 128'(err), 128'(0));

        res  = 128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D;
        res2 = 128'hFFFF0000_EEEE1111_DDDD2222_CCCC3333;
        ext_dout_ready = 1'b0;
        core_done = 1'b1; core_dout = res; push_result(res);
        tick();
        core_dout = res2;
        tick();
        core_done = 1'b0;
        check("ovr_err", 128'(err), 128'(1));
        run_drain(1'b0);
        settle(3);
        scoreboard("ovr");
        do_reset();
        check("ovr_err_clr", 128'(err), 128'(0));

        // core_done in the same cycle as the final accept must not reload.
        ext_dout_ready = 1'b1;
        core_done = 1'b1; core_dout = res2; push_result(res2);
        tick();
        core_done = 1'b0;
        settle(3);
        check("fa_last", 128'(ext_dout), 128'(word_of(res2, 3)));
        core_done = 1'b1; core_dout = res;
        tick();
        core_done = 1'b0;
        check("fa_err", 128'(err), 128'(1));
        run_drain(1'b0);
        settle(5);
        scoreboard("fa");

        // Reset two beats into a key fill aborts it cleanly.
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        check("pre_rst_err", 128'(err), 128'(1));
        core_load_k = 1'b1;
        tick();
        core_load_k = 1'b0;
        ext_valid = 1'b1; ext_din = word_of(blk, 0);
        tick();
        ext_din = word_of(blk, 1);
        tick();
        ext_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_clear", 128'({ext_ready, ext_req_k, err}), 128'(0));
        check("midrst_core_rst", 128'(core_rst), 128'(1));
        tick();
        check("midrst_core_rst_off", 128'(core_rst), 128'(0));
        settle(4);
        scoreboard("midrst");
        blk = 128'hFACEB00C_0BADF00D_5EED5EED_C0FFEE00;
        fill_block(1'b1, blk, 1'b0, -1, 1'b0, 128'h0);
        settle(3);
        scoreboard("refill");
        check("refill_err", 128'(err), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
